mux4_rr_arbiter: RTL

- Round-robin arbiter and output register that shares the calculator's 16-bit 4:1 operand/result mux between four requesters.
- Each requester presents data with a valid/ready handshake.
- The arbiter drives the mux select, captures the winning word into a registered output stage, and offers it downstream with valid/ready.
- Sits between the operand sources (register file ports, immediate, ALU feedback) and the ALU input stage.

---
 rtl/calc_pkg.sv | 15 +
 rtl/mux4_rr_arbiter_if.sv | 29 ++
 rtl/mux4_1_rtl.sv | 25 ++
 rtl/mux4_rr_arbiter.sv | 73 +++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator datapath constants: operand width, source count and source indices.
package calc_pkg;

  localparam int unsigned CALC_WIDTH = 16;
  localparam int unsigned NUM_SRC    = 4;
  localparam int unsigned SRC_IDX_W  = 2;

  typedef logic [SRC_IDX_W-1:0] src_idx_t;

  localparam src_idx_t SRC_RF_A = 2'd0;
  localparam src_idx_t SRC_RF_B = 2'd1;
  localparam src_idx_t SRC_IMM  = 2'd2;
  localparam src_idx_t SRC_ALU  = 2'd3;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle for the shared operand mux arbiter.
// master = operand sources and ALU input stage; slave = the arbiter.
interface mux4_rr_arbiter_if import calc_pkg::*; #(
  parameter int unsigned WIDTH = CALC_WIDTH
);

  logic [NUM_SRC-1:0] src_valid;
  logic [NUM_SRC-1:0] src_ready;
  logic [WIDTH-1:0]   d0;
  logic [WIDTH-1:0]   d1;
  logic [WIDTH-1:0]   d2;
  logic [WIDTH-1:0]   d3;
  src_idx_t           sel;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  src_idx_t           out_src;

  modport master (
    output src_valid, d0, d1, d2, d3, out_ready,
    input  src_ready, sel, out_valid, out_data, out_src
  );

  modport slave (
    input  src_valid, d0, d1, d2, d3, out_ready,
    output src_ready, sel, out_valid, out_data, out_src
  );

endinterface

// File: rtl/mux4_1_rtl.sv
// Calculator 16-bit 4:1 operand/result mux; s picks which of d0..d3 appears on y.
module mux4_1_rtl import calc_pkg::*; #(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  src_idx_t         s,
  output logic [WIDTH-1:0] y
);

  // Pure combinational select.
  always_comb begin
    y = d0;
    case (s)
      SRC_RF_A: y = d0;
      SRC_RF_B: y = d1;
      SRC_IMM:  y = d2;
      SRC_ALU:  y = d3;
      default:  y = d0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing the calculator 4:1 operand mux among four
// valid/ready requesters, with a one-deep registered output stage.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed 0>1>2>3 priority
// (regression only; source 3 can starve). The interface WIDTH must match WIDTH.
module mux4_rr_arbiter import calc_pkg::*; #(
  parameter int unsigned WIDTH     = CALC_WIDTH,
  parameter src_idx_t    RESET_PTR = 2'd3
) (
  input  logic              clk,
  input  logic              rst,
  mux4_rr_arbiter_if.slave  bus
);

  src_idx_t         ptr;
  src_idx_t         win;
  src_idx_t         cand;
  logic             any_valid;
  logic             load_en;
  logic [WIDTH-1:0] mux_y;

  assign any_valid = |bus.src_valid;
  assign load_en   = !bus.out_valid || bus.out_ready;

  // Winner scan: walk candidates from last to first so the first valid one sticks;
  // with no request the select parks on ptr.
  always_comb begin
    win  = ptr;
    cand = ptr;
    for (int k = int'(NUM_SRC); k >= 1; k--) begin
`ifdef ARB_FIXED_PRIO_EN
      cand = SRC_IDX_W'(k - 1);
`else
      cand = ptr + SRC_IDX_W'(k);
`endif
      if (bus.src_valid[cand]) begin
        win = cand;
      end
    end
  end

  assign bus.sel       = win;
  assign bus.src_ready = (!rst && load_en && any_valid) ? (NUM_SRC'(1) << win) : '0;

  // Data path goes only through the shared mux; the arbiter just steers it.
  mux4_1_rtl #(.WIDTH(WIDTH)) u_mux (
    .d0 (bus.d0),
    .d1 (bus.d1),
    .d2 (bus.d2),
    .d3 (bus.d3),
    .s  (win),
    .y  (mux_y)
  );

  // Output stage: out_valid is the EMPTY/FULL state; load on grant, drain when idle, hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      ptr           <= RESET_PTR;
    end else if (load_en) begin
      if (any_valid) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= mux_y;
        bus.out_src   <= win;
        ptr           <= win;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule
